corelet_inst_seq: RTL

//   Instruction sequencer: generates the 35-bit inst word and the SRAM controls that drive one corelet through a full conv layer.
//   WS mode: per kernel position kij, load weights, stream activations, drain psums to PMEM, then run SFP accumulation.
//   OS mode: per kij, fill IFIFO/L0 and execute.

---
 rtl/corelet_inst_seq.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/corelet_inst_seq.sv
// Instruction sequencer for one corelet. It steps a WS or OS conv layer through
// L0/IFIFO fills, PE execution, OFIFO drain and, in WS mode, SFP accumulation.
module corelet_inst_seq #(
    parameter int row   = 8,
    parameter int col   = 8,
    parameter int KIJ   = 9,
    parameter int NIJ   = 36,
    parameter int AW    = 11,
    parameter int WBASE = 128,
    parameter int OBASE = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic          l0_full,
    input  logic          ififo_full,
    input  logic          ofifo_valid,
    output logic [34:0]   inst,
    output logic          xmem_cen,
    output logic [AW-1:0] xmem_addr,
    output logic          pmem_cen,
    output logic          pmem_wen,
    output logic [AW-1:0] pmem_addr,
    output logic          busy,
    output logic          done
);
    localparam int CW = 16;
    localparam logic [CW-1:0] ROW_C   = CW'(row);
    localparam logic [CW-1:0] COL_C   = CW'(col);
    localparam logic [CW-1:0] KIJ_C   = CW'(KIJ);
    localparam logic [CW-1:0] NIJ_C   = CW'(NIJ);
    localparam logic [CW-1:0] WBASE_C = CW'(WBASE);
    localparam logic [CW-1:0] OBASE_C = CW'(OBASE);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_FILL,
        S_W_LOAD,
        S_A_FILL,
        S_A_EXE,
        S_O_DRAIN,
        S_ACC,
        S_OS_FILL,
        S_OS_EXE,
        S_DONE
    } state_t;

    state_t        state;
    logic          mode_q;
    logic          pend_act;
    logic          fill_stall;
    logic [CW-1:0] kij;
    logic [CW-1:0] cnt;
    logic [CW-1:0] sub;
    logic [CW-1:0] fill_len;
    logic [CW-1:0] fill_addr;
    logic [CW-1:0] drain_len;
    logic [CW-1:0] drain_addr;
    logic [CW-1:0] acc_addr;

    // OS fills alternate weight (even cnt) and activation (odd cnt) reads.
    always_comb begin
        fill_len   = NIJ_C;
        fill_addr  = cnt;
        fill_stall = l0_full;
        case (state)
            S_W_FILL: begin
                fill_len  = COL_C;
                fill_addr = WBASE_C + kij * COL_C + cnt;
            end
            S_OS_FILL: begin
                fill_len   = COL_C << 1;
                fill_addr  = cnt[0] ? kij * ROW_C + (cnt >> 1)
                                    : WBASE_C + kij * COL_C + (cnt >> 1);
                fill_stall = l0_full | ififo_full;
            end
            default: ;
        endcase
        drain_len  = mode_q ? ROW_C : NIJ_C;
        drain_addr = (mode_q ? OBASE_C : kij * NIJ_C) + sub;
        acc_addr   = cnt * NIJ_C + sub;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            inst      <= '0;
            xmem_cen  <= 1'b1;
            xmem_addr <= '0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            pmem_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mode_q    <= 1'b0;
            pend_act  <= 1'b0;
            kij       <= '0;
            cnt       <= '0;
            sub       <= '0;
        end else begin
            inst     <= '0;
            inst[34] <= mode_q;
            xmem_cen <= 1'b1;
            pmem_cen <= 1'b1;
            pmem_wen <= 1'b1;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    inst[34] <= 1'b0;
                    if (start) begin
                        mode_q   <= mode;
                        inst[34] <= mode;
                        busy     <= 1'b1;
                        kij      <= '0;
                        cnt      <= '0;
                        sub      <= '0;
                        state    <= mode ? S_OS_FILL : S_W_FILL;
                    end
                end
                // A read issued last cycle is always written now, even while stalled.
                S_W_FILL, S_A_FILL, S_OS_FILL: begin
                    assert ((fill_addr >> AW) == '0);
                    inst[2] <= ~xmem_cen && (state != S_OS_FILL || pend_act);
                    inst[4] <= ~xmem_cen && state == S_OS_FILL && !pend_act;
                    if (cnt < fill_len) begin
                        if (!fill_stall) begin
                            xmem_cen  <= 1'b0;
                            xmem_addr <= AW'(fill_addr);
                            pend_act  <= cnt[0];
                            cnt       <= cnt + 1'b1;
                        end
                    end else if (xmem_cen) begin
                        cnt   <= '0;
                        state <= (state == S_W_FILL) ? S_W_LOAD :
                                 (state == S_A_FILL) ? S_A_EXE  : S_OS_EXE;
                    end
                end
                S_W_LOAD: begin
                    if (cnt < COL_C) begin
                        inst[3] <= 1'b1;
                        inst[0] <= 1'b1;
                    end
                    if (cnt == COL_C + ROW_C + COL_C - 1'b1) begin
                        cnt   <= '0;
                        state <= S_A_FILL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_A_EXE: begin
                    inst[3] <= 1'b1;
                    inst[1] <= 1'b1;
                    if (cnt == NIJ_C - 1'b1) begin
                        cnt   <= '0;
                        sub   <= '0;
                        state <= S_O_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OS_EXE: begin
                    if (cnt < ROW_C) begin
                        inst[3] <= 1'b1;
                        inst[1] <= 1'b1;
                    end
                    if (cnt == ROW_C + ROW_C + COL_C - 1'b1) begin
                        cnt <= '0;
                        sub <= '0;
                        if (kij < KIJ_C - 1'b1) begin
                            kij   <= kij + 1'b1;
                            state <= S_OS_FILL;
                        end else begin
                            state <= S_O_DRAIN;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // cnt counts OFIFO reads, sub counts PMEM writes trailing them by a cycle.
                S_O_DRAIN: begin
                    assert ((drain_addr >> AW) == '0);
                    if (inst[6]) begin
                        pmem_cen  <= 1'b0;
                        pmem_wen  <= 1'b0;
                        pmem_addr <= AW'(drain_addr);
                        sub       <= sub + 1'b1;
                    end
                    if (cnt < drain_len) begin
                        if (ofifo_valid) begin
                            inst[6] <= 1'b1;
                            cnt     <= cnt + 1'b1;
                        end
                    end else if (sub == drain_len) begin
                        cnt <= '0;
                        sub <= '0;
                        if (mode_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else if (kij < KIJ_C - 1'b1) begin
                            kij   <= kij + 1'b1;
                            state <= S_W_FILL;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                // Per output pixel: KIJ partial-sum reads, then one write of the sum.
                S_ACC: begin
                    assert ((acc_addr >> AW) == '0 && ((OBASE_C + sub) >> AW) == '0);
                    inst[33] <= ~pmem_cen && pmem_wen;
                    if (sub == NIJ_C) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (cnt < KIJ_C) begin
                        pmem_cen  <= 1'b0;
                        pmem_addr <= AW'(acc_addr);
                        cnt       <= cnt + 1'b1;
                    end else begin
                        pmem_cen  <= 1'b0;
                        pmem_wen  <= 1'b0;
                        pmem_addr <= AW'(OBASE_C + sub);
                        cnt       <= '0;
                        sub       <= sub + 1'b1;
                    end
                end
                S_DONE: begin
                    inst[34] <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
